// File: rtl/cpu_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_monitor
// Purpose  : Run controller and result dumper wrapped around a CPU core.
//            Releases the core from reset on start, counts cycles until the
//            core reports completion or the cycle budget expires, snapshots
//            the register file and streams it out one register per beat.
// Revision : 1.0  initial release
// ============================================================================
module cpu_run_monitor #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int MAX_CYCLES = 100000,
  parameter int CNT_W      = 32,
  parameter int IDX_W      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  completed,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  output logic                  cpu_rstn,
  output logic [CNT_W-1:0]      cycle_count,
  output logic                  timeout,
  output logic                  busy,
  output logic                  done,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [IDX_W-1:0]      dump_index,
  output logic [XLEN-1:0]       dump_data,
  output logic                  dump_last
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DUMP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NREGS - 1);
  localparam logic [CNT_W-1:0] BUDGET_END = CNT_W'(MAX_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_next;
  logic             budget_hit;
  logic             capture;
  logic             beat_xfer;
  logic [XLEN-1:0]  snap [NREGS];

  // Next-count and exit conditions; completion and budget only matter in RUN
  assign cnt_next   = cycle_count + 1'b1;
  assign budget_hit = (cnt_next == BUDGET_END);
  assign capture    = (state == RUN) && (completed || budget_hit);
  assign beat_xfer  = (state == DUMP) && dump_ready;

  // Every output is a decode of registered state, never of a live input
  assign cpu_rstn   = (state == RUN);
  assign busy       = (state == RUN) || (state == DUMP);
  assign done       = (state == DONE);
  assign dump_valid = (state == DUMP);
  assign dump_last  = dump_valid && (dump_index == LAST_IDX);
  assign dump_data  = snap[dump_index];

  // Register-file snapshot, taken only on the edge that leaves RUN
  for (genvar i = 0; i < NREGS; i++) begin : g_snap
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        snap[i] <= '0;
      end else if (capture) begin
        snap[i] <= regs_flat[i*XLEN +: XLEN];
      end
    end
  end

  // Run/dump sequencer: cycle counting, timeout flag and beat index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cycle_count <= '0;
      timeout     <= 1'b0;
      dump_index  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            cycle_count <= '0;
            timeout     <= 1'b0;
          end
        end
        RUN: begin
          // The exit edge is counted too, so the count tops out at the budget
          cycle_count <= cnt_next;
          if (completed) begin
            timeout <= 1'b0;
            state   <= DUMP;
          end else if (budget_hit) begin
            timeout <= 1'b1;
            state   <= DUMP;
          end
        end
        DUMP: begin
          if (beat_xfer) begin
            if (dump_index == LAST_IDX) begin
              dump_index <= '0;
              state      <= DONE;
            end else begin
              dump_index <= dump_index + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable run controller and result dumper placed around the cpu core.
- Releases the core from reset on command and counts cycles until the core asserts completion or a cycle budget runs out.
- Snapshots the core's register file and streams it out one register per beat over a valid/ready interface.
- Replaces fixed bench-side clock loops and register dumps with a parametrised block usable in simulation and on FPGA.

Parameters:
- XLEN, 32, width of one architectural register.
- NREGS, 32, number of registers snapshotted and dumped (>=2).
- MAX_CYCLES, 100000, cycle budget per run (>=1).
- CNT_W, 32, cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.
- IDX_W, $clog2(NREGS), width of dump_index.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled only in IDLE and DONE.
- completed  in  1  core completion flag; sampled only in RUN.
- regs_flat  in  NREGS*XLEN  core register file; reg i at [i*XLEN +: XLEN].
- cpu_rstn  out  1  reset to core; 1 only while in RUN.
- cycle_count  out  CNT_W  cycles spent in the current/last run.
- timeout  out  1  last run ended by budget, not completion.
- busy  out  1  state is RUN or DUMP.
- done  out  1  state is DONE.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts beat.
- dump_index  out  IDX_W  register number of current beat.
- dump_data  out  XLEN  snapshot value of register dump_index.
- dump_last  out  1  current beat is register NREGS-1.

Behaviour:
- Async reset (rstn=0): state IDLE.
- Outputs under reset: cpu_rstn=0, cycle_count=0, timeout=0, busy=0, done=0, dump_valid=0, dump_index=0, dump_last=0.
- Snapshot array is cleared to 0 under reset, so dump_data=0.
- Reset mid-run or mid-dump aborts immediately to these values.
- All outputs are derived from registers only. No combinational path from dump_ready or completed to any output.
- FSM states: IDLE, RUN, DUMP, DONE.
- IDLE:
  - start=1 -> RUN; cycle_count<=0, timeout<=0.
  - cpu_rstn becomes 1 the cycle after start is sampled.
- RUN:
  - Each edge: cycle_count<=cycle_count+1.
  - If completed=1: snapshot<=regs_flat, timeout<=0, go DUMP.
  - Else if cycle_count+1==MAX_CYCLES: snapshot<=regs_flat, timeout<=1, go DUMP.
  - completed has priority over budget expiry in the same cycle.
  - cycle_count therefore includes the exit edge: completed on the first RUN cycle gives 1; the maximum value is MAX_CYCLES.
  - cpu_rstn drops to 0 on the exit edge.
- DUMP:
  - dump_valid=1, dump_index starts at 0, dump_data=snapshot[dump_index], dump_last=(dump_index==NREGS-1).
  - A beat transfers on an edge with dump_valid & dump_ready; then dump_index increments.
  - When dump_valid=1 and dump_ready=0, dump_index and dump_data hold stable.
  - On transfer of the last beat: dump_valid<=0, dump_index<=0, go DONE.
  - Exactly NREGS beats, in ascending index order. No bubbles when dump_ready is held high (one beat per cycle).
- DONE:
  - done=1; cycle_count, timeout and snapshot hold.
  - start=1 -> RUN, with the same clears as from IDLE; done drops the next cycle.
- Ignored inputs:
  - start is ignored in RUN and DUMP.
  - completed is ignored outside RUN.
  - regs_flat is sampled only on the RUN exit edge; later changes do not affect the dump.
- cycle_count never wraps within a run, because the budget caps it at MAX_CYCLES.

Test Plan:
1. Normal run, defaults: start pulse, completed asserted on the 5th RUN cycle, reg i = i*3, dump_ready=1 -> cpu_rstn high exactly 5 cycles, cycle_count=5, timeout=0, 32 consecutive beats 0,3,...,93, dump_last only on index 31, then done=1.
2. Timeout, MAX_CYCLES=20, completed never set -> exit after 20 RUN cycles, cycle_count=20, timeout=1, full dump follows.
3. Simultaneous completion and expiry, MAX_CYCLES=20, completed=1 on the 20th cycle -> timeout=0, cycle_count=20.
4. Backpressure: dump_ready pattern 1,0,0,1,0,1... -> dump_index/dump_data stable while stalled, no skipped or duplicated indices.
5. Snapshot isolation: change regs_flat to all 0xFFFFFFFF after exit -> dumped values are the pre-exit ones.
6. Reset and restart:
   - rstn=0 during DUMP at index 10 -> all outputs at reset values.
   - After release, start -> clean new run.
   - From DONE, a second start with completed on cycle 3 -> cycle_count=3, timeout cleared.
